// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and address helpers for data_memory_ctrl
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

  // The array is top-aligned, so its lowest word sits DEPTH-1 words below TOP_ADDR.
  function automatic logic [31:0] dmem_base(input logic [31:0] top_addr, input int unsigned depth);
    return top_addr - 32'(4 * (depth - 1));
  endfunction

endpackage

// File: rtl/data_memory_ctrl_if.sv
// rtl/data_memory_ctrl_if.sv - request/response bus between load/store unit and data memory
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy_clear;

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clear
  );

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy_clear
  );
endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store byte-enable/replication and load lane extract/extend
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata     = '0;
    // off is already aligned to the access size, so a single shift lands the lane at bit 0
    shifted   = rword >> {off, 3'b000};
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = {{24{sgn & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be        = off[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = {{16{sgn & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be        = 4'b1111;
        rdata     = shifted;
      end
      default: begin
        be        = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// rtl/data_memory_ctrl.sv - top-aligned data memory with handshake, latency pipe and zero-clear
// Optional DMEM_MISALIGN_ERR_EN: misaligned accesses error instead of being force-aligned.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 1024,
  parameter logic [31:0] TOP_ADDR       = 32'h3ffc,
  parameter int unsigned READ_LAT       = 1,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input logic               clk,
  input logic               rst_n,
  data_memory_ctrl_if.slave bus
);

  localparam logic [31:0] BASE  = dmem_base(TOP_ADDR, DEPTH);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e                         state_q, state_d;
  logic [IDX_W-1:0]               clr_cnt_q, clr_cnt_d;
  logic                           busy_clear_q, busy_clear_d;
  logic                           req_ready_q, req_ready_d;
  logic [READ_LAT-1:0]            pv_q, pv_d;
  logic [READ_LAT-1:0]            pe_q, pe_d;
  logic [READ_LAT-1:0][31:0]      pd_q, pd_d;

  logic [DATA_W-1:0]              mem_q [DEPTH];

  logic [31:0]                    addr_off;
  logic [IDX_W-1:0]               idx;
  logic [1:0]                     lane_off;
  logic                           in_range;
  logic                           acc_err;
  logic                           accept;
  logic                           store_en;
  logic                           clear_en;
  logic [3:0]                     be;
  logic [31:0]                    wdata_rep;
  logic [31:0]                    ld_data;
  logic [DATA_W-1:0]              rd_word;
  logic                           unused_addr_bits;

  assign addr_off         = bus.req_addr - BASE;
  assign idx              = addr_off[IDX_W+1:2];
  assign unused_addr_bits = ^{addr_off[31:IDX_W+2], addr_off[1:0]};
  assign in_range         = (bus.req_addr >= BASE) && (bus.req_addr <= TOP_ADDR + 32'd3);

`ifdef DMEM_MISALIGN_ERR_EN
  logic misalign;
  assign misalign = ((bus.req_size == SZ_HALF) && bus.req_addr[0]) ||
                    ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));
  assign acc_err  = (bus.req_size == SZ_RSVD) || !in_range || misalign;
`else
  assign acc_err  = (bus.req_size == SZ_RSVD) || !in_range;
`endif

  // Low address bits that don't fit the access size are dropped; in error builds they never matter.
  always_comb begin
    lane_off = bus.req_addr[1:0];
    case (bus.req_size)
      SZ_HALF: lane_off = {bus.req_addr[1], 1'b0};
      SZ_WORD: lane_off = 2'b00;
      default: lane_off = bus.req_addr[1:0];
    endcase
  end

  assign accept   = rst_n & bus.req_valid & req_ready_q;
  assign store_en = accept & bus.req_we & ~acc_err;
  assign clear_en = rst_n & (state_q == ST_CLEAR);
  assign rd_word  = mem_q[idx];

  dmem_lane_align u_align (
    .size      (bus.req_size),
    .sgn       (bus.req_signed),
    .off       (lane_off),
    .wdata     (bus.req_wdata),
    .rword     (rd_word),
    .be        (be),
    .wdata_rep (wdata_rep),
    .rdata     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (clear_en) begin
      mem_q[clr_cnt_q] <= '0;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    busy_clear_d = busy_clear_q;
    req_ready_d  = req_ready_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d      = ST_RUN;
          busy_clear_d = 1'b0;
          req_ready_d  = 1'b1;
          clr_cnt_d    = '0;
        end
      end
      default: begin
        req_ready_d = 1'b1;
      end
    endcase
  end

  // Stage 0 captures the response at the accept edge; the last stage drives the bus.
  always_comb begin
    pv_d = pv_q;
    pe_d = pe_q;
    pd_d = pd_q;
    for (int i = int'(READ_LAT) - 1; i > 0; i--) begin
      pv_d[i] = pv_q[i-1];
      pe_d[i] = pe_q[i-1];
      pd_d[i] = pd_q[i-1];
    end
    pv_d[0] = accept;
    pe_d[0] = accept & acc_err;
    pd_d[0] = (accept & ~bus.req_we & ~acc_err) ? ld_data : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q    <= '0;
      busy_clear_q <= (CLEAR_ON_RESET != 0);
      req_ready_q  <= 1'b0;
      pv_q         <= '0;
      pe_q         <= '0;
      pd_q         <= '0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      busy_clear_q <= busy_clear_d;
      req_ready_q  <= req_ready_d;
      pv_q         <= pv_d;
      pe_q         <= pe_d;
      pd_q         <= pd_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy_clear = busy_clear_q;
  assign bus.rsp_valid  = pv_q[READ_LAT-1];
  assign bus.rsp_err    = pe_q[READ_LAT-1];
  assign bus.rsp_rdata  = pd_q[READ_LAT-1];

endmodule
